apb_csr_ctrl: RTL and testbench
===============================

# apb_csr_ctrl

APB slave controller that sequences reads and writes into the CSR register bank built from the team's 8-bit enable-gated flops. It runs the APB transfer state machine, inserts a programmable number of wait states, decodes the word address into a one-hot write-enable pulse, and muxes register outputs back onto PRDATA. It sits between the APB interconnect and the register bank; the bank flops hold state, and this block decides when each one loads.

## Interface
- NUM_REGS, 5: number of CSR registers in the bank (word-addressed, index 0..NUM_REGS-1).
- ADDR_WIDTH, 3: width of the word-index address.
- WAIT_STATES, 1: APB wait cycles (PREADY low) per transfer; 0..15 legal.
- RO_MASK, 5'b00001: bit i set = register i is read-only.
- i_clk  in  1  single clock; all state on its rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_psel  in  1  APB select.
- i_penable  in  1  APB enable (access phase).
- i_pwrite  in  1  1 = write, 0 = read.
- i_paddr  in  ADDR_WIDTH  register word index.
- i_pwdata  in  8  write data.
- o_prdata  out  8  read data; valid only while o_pready=1 on a read.
- o_pready  out  1  transfer completes this cycle.
- o_pslverr  out  1  error response; valid only while o_pready=1.
- o_wr_en  out  NUM_REGS  one-hot write-enable pulse to register i.
- o_wr_data  out  8  data to all register D inputs.
- i_rd_data  in  NUM_REGS*8  concatenated register outputs, register i at [8i+7:8i].

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: on i_psel=1 & i_penable=0 (setup phase) latch paddr, pwrite, pwdata; compute err = (paddr >= NUM_REGS) | (pwrite & RO_MASK[paddr]); load wait counter with WAIT_STATES; go to WAIT if WAIT_STATES>0 else DONE.
- WAIT: counter decrements each cycle; at count 1 go to DONE. If i_psel drops, abort to IDLE with no write and no response.
- DONE (one cycle): o_pready=1; o_pslverr=err; read with !err drives o_prdata = i_rd_data[latched index]; write with !err drives o_wr_en[index]=1, o_wr_data=latched pwdata. Always returns to IDLE.
- Errored transfer: o_prdata=0, o_wr_en all 0, bank unchanged.
- All outputs are registered; no combinational path from APB inputs to outputs.
- Outside DONE: o_pready=0, o_pslverr=0, o_prdata=0, o_wr_en=0; o_wr_data holds last value.

## Timing
- Reset (async, immediate): state IDLE, counter 0, o_pready=0, o_pslverr=0, o_prdata=0, o_wr_en=0, o_wr_data=0. Reset mid-transfer drops any pending write; wr_en never pulses after release for that transfer.
- Setup cycle T0; access phase T1..T1+WAIT_STATES; o_pready high in cycle T1+WAIT_STATES only.
- Write lands: o_wr_en high in the same cycle as o_pready; register holds new value from the following cycle.
- Read samples i_rd_data at the edge entering DONE; a write completing in the cycle before is visible.
- Back-to-back: next setup phase may occur the cycle after DONE; throughput 2+WAIT_STATES cycles/transfer.
- i_penable=1 seen in IDLE (no setup) is ignored.

## Structure
- Package apb_csr_pkg: state enum (IDLE/WAIT/DONE), CSR_DATA_W=8, default NUM_REGS and RO_MASK.
- Sub-module apb_csr_addr_dec: combinational index → one-hot enable plus out-of-range/read-only error flag; instantiated once.
- FSM, wait counter and read mux in the top.

## Test plan
- Reset: hold i_rst_n=0 mid-WAIT of a write to reg 2 → all outputs 0 immediately; reg 2 unchanged after release.
- Write 0xA5 to reg 3, WAIT_STATES=1 → o_pready high exactly 2 cycles after setup; o_wr_en=5'b01000 that cycle; readback 0xA5, pslverr=0.
- Write to reg 0 (RO) and to index 6 → o_pslverr=1 with o_pready, o_wr_en stays 0; read index 6 → prdata=0, pslverr=1.
- Back-to-back write 0x3C reg 1 then read reg 1 → read returns 0x3C, second o_pready 3 cycles after first.
- WAIT_STATES=0 → o_pready in first access cycle; WAIT_STATES=3 → PREADY low 3 access cycles, high on 4th.
- Drop i_psel during WAIT → return to IDLE, no o_pready, no o_wr_en; next legal transfer completes normally.

Source files
------------

// File: rtl/apb_csr_pkg.sv
// Shared types and constants for the APB CSR controller and its address decoder.
package apb_csr_pkg;

  // APB transfer sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_state_e;

  localparam int CSR_DATA_W      = 8;
  localparam int DEF_NUM_REGS    = 5;
  localparam int DEF_ADDR_WIDTH  = 3;
  localparam int DEF_WAIT_STATES = 1;
  localparam logic [DEF_NUM_REGS-1:0] DEF_RO_MASK = 5'b00001;

  // Wait counter is wide enough for the full 0..15 wait-state range.
  localparam int WAIT_CNT_W = 4;
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE = 4'd1;

endpackage

// File: rtl/apb_csr_addr_dec.sv
// Word-index decoder: one-hot register select plus out-of-range / read-only error.
module apb_csr_addr_dec
  import apb_csr_pkg::*;
#(
  parameter int                  NUM_REGS   = DEF_NUM_REGS,
  parameter int                  ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [NUM_REGS-1:0] RO_MASK    = DEF_RO_MASK
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  is_write,
  output logic [NUM_REGS-1:0]   onehot,
  output logic                  err
);

  logic hit_s;
  logic ro_s;

  // Match the index against every implemented register; no match means out of range.
  always_comb begin
    onehot = '0;
    hit_s  = 1'b0;
    ro_s   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        onehot[i] = 1'b1;
        hit_s     = 1'b1;
        ro_s      = RO_MASK[i];
      end else begin
        onehot[i] = 1'b0;
      end
    end
    err = ~hit_s | (is_write & ro_s);
  end

endmodule

// File: rtl/apb_csr_ctrl.sv
// APB slave that sequences CSR bank loads and read-back with programmable wait states.
module apb_csr_ctrl
  import apb_csr_pkg::*;
#(
  parameter int                  NUM_REGS    = DEF_NUM_REGS,
  parameter int                  ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int                  WAIT_STATES = DEF_WAIT_STATES,
  parameter logic [NUM_REGS-1:0] RO_MASK     = DEF_RO_MASK
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic                           i_pwrite,
  input  logic [ADDR_WIDTH-1:0]          i_paddr,
  input  logic [CSR_DATA_W-1:0]          i_pwdata,
  output logic [CSR_DATA_W-1:0]          o_prdata,
  output logic                           o_pready,
  output logic                           o_pslverr,
  output logic [NUM_REGS-1:0]            o_wr_en,
  output logic [CSR_DATA_W-1:0]          o_wr_data,
  input  logic [NUM_REGS*CSR_DATA_W-1:0] i_rd_data
);

  apb_state_e              state_r;
  logic [WAIT_CNT_W-1:0]   cnt_r;
  logic                    write_r;
  logic [CSR_DATA_W-1:0]   wdata_r;
  logic [NUM_REGS-1:0]     onehot_r;
  logic                    err_r;

  logic                    setup_s;
  logic [NUM_REGS-1:0]     dec_onehot_s;
  logic                    dec_err_s;
  logic                    go_done_s;
  logic                    fin_write_s;
  logic [CSR_DATA_W-1:0]   fin_wdata_s;
  logic [NUM_REGS-1:0]     fin_onehot_s;
  logic                    fin_err_s;
  logic                    ok_wr_s;
  logic                    ok_rd_s;
  logic [CSR_DATA_W-1:0]   rd_sel_s;

  assign setup_s = i_psel & ~i_penable;

  apb_csr_addr_dec #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RO_MASK    (RO_MASK)
  ) u_addr_dec (
    .addr     (i_paddr),
    .is_write (i_pwrite),
    .onehot   (dec_onehot_s),
    .err      (dec_err_s)
  );

  // Decide whether the next edge enters DONE and which transfer attributes complete there;
  // with zero wait states the setup-phase inputs complete directly.
  always_comb begin
    go_done_s    = 1'b0;
    fin_write_s  = write_r;
    fin_wdata_s  = wdata_r;
    fin_onehot_s = onehot_r;
    fin_err_s    = err_r;
    case (state_r)
      IDLE: begin
        if (setup_s && (WAIT_STATES == 0)) begin
          go_done_s    = 1'b1;
          fin_write_s  = i_pwrite;
          fin_wdata_s  = i_pwdata;
          fin_onehot_s = dec_onehot_s;
          fin_err_s    = dec_err_s;
        end else begin
          go_done_s = 1'b0;
        end
      end
      WAIT: begin
        if (i_psel && (cnt_r == CNT_ONE)) begin
          go_done_s = 1'b1;
        end else begin
          go_done_s = 1'b0;
        end
      end
      default: go_done_s = 1'b0;
    endcase
    ok_wr_s = go_done_s & fin_write_s & ~fin_err_s;
    ok_rd_s = go_done_s & ~fin_write_s & ~fin_err_s;
  end

  // Read mux: AND-OR select of the register addressed by the completing transfer.
  always_comb begin
    rd_sel_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_sel_s = rd_sel_s | ({CSR_DATA_W{fin_onehot_s[i]}} & i_rd_data[CSR_DATA_W*i +: CSR_DATA_W]);
    end
  end

  // Transfer FSM, wait counter, latched request and registered APB/bank outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      write_r   <= 1'b0;
      wdata_r   <= '0;
      onehot_r  <= '0;
      err_r     <= 1'b0;
      o_pready  <= 1'b0;
      o_pslverr <= 1'b0;
      o_prdata  <= '0;
      o_wr_en   <= '0;
      o_wr_data <= '0;
    end else begin
      o_pready  <= go_done_s;
      o_pslverr <= go_done_s & fin_err_s;
      o_prdata  <= ok_rd_s ? rd_sel_s : '0;
      o_wr_en   <= ok_wr_s ? fin_onehot_s : '0;
      if (ok_wr_s) begin
        o_wr_data <= fin_wdata_s;
      end else begin
        o_wr_data <= o_wr_data;
      end
      case (state_r)
        IDLE: begin
          if (setup_s) begin
            write_r  <= i_pwrite;
            wdata_r  <= i_pwdata;
            onehot_r <= dec_onehot_s;
            err_r    <= dec_err_s;
            cnt_r    <= WAIT_CNT_W'(WAIT_STATES);
            state_r  <= go_done_s ? DONE : WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (!i_psel) begin
            cnt_r   <= '0;
            state_r <= IDLE;
          end else if (go_done_s) begin
            cnt_r   <= '0;
            state_r <= DONE;
          end else begin
            cnt_r   <= cnt_r - CNT_ONE;
            state_r <= WAIT;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_csr_ctrl.sv
// Directed bench for apb_csr_ctrl: three instances with 1, 0 and 3 wait states,
// each backed by a simple register bank model that is not cleared by reset.
module tb_apb_csr_ctrl;

  localparam int NR = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   stray = 0;

  logic          psel    [3];
  logic          penable [3];
  logic          pwrite  [3];
  logic [2:0]    paddr   [3];
  logic [7:0]    pwdata  [3];
  logic [7:0]    prdata  [3];
  logic          pready  [3];
  logic          pslverr [3];
  logic [NR-1:0] wr_en   [3];
  logic [7:0]    wr_data [3];
  logic [NR*8-1:0] bank  [3] = '{default: '0};

  logic [7:0]    x_rd;
  logic          x_err;
  logic [NR-1:0] x_we;
  logic [7:0]    x_wd;
  int            x_lat;
  int            x_at;
  int            a1;
  int            hits;

  always #5 clk = ~clk;

  // Free-running cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Register bank model: loads each enabled register from wr_data.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++)
      for (int r = 0; r < NR; r++)
        if (wr_en[g][r]) bank[g][8*r +: 8] <= wr_data[g];
  end

  // Count any write-enable seen outside a completing cycle.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++)
      if ((wr_en[g] != '0) && !pready[g]) stray <= stray + 1;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_csr_ctrl #(
      .NUM_REGS    (NR),
      .ADDR_WIDTH  (3),
      .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
      .RO_MASK     (5'b00001)
    ) u_dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_psel    (psel[g]),
      .i_penable (penable[g]),
      .i_pwrite  (pwrite[g]),
      .i_paddr   (paddr[g]),
      .i_pwdata  (pwdata[g]),
      .o_prdata  (prdata[g]),
      .o_pready  (pready[g]),
      .o_pslverr (pslverr[g]),
      .o_wr_en   (wr_en[g]),
      .o_wr_data (wr_data[g]),
      .i_rd_data (bank[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One APB transfer on instance d; results land in the x_* variables.
  task automatic xfer(input int d, input bit wr, input logic [2:0] a, input logic [7:0] wd);
    @(negedge clk);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(negedge clk);
    penable[d] = 1'b1;
    x_lat = 1;
    while (!pready[d] && x_lat < 20) begin
      @(negedge clk);
      x_lat++;
    end
    x_rd = prdata[d]; x_err = pslverr[d]; x_we = wr_en[d]; x_wd = wr_data[d]; x_at = cyc;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      psel[g] = 1'b0; penable[g] = 1'b0; pwrite[g] = 1'b0; paddr[g] = 3'd0; pwdata[g] = 8'h00;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pready",  32'(pready[0]),  32'd0);
    chk("rst_pslverr", 32'(pslverr[0]), 32'd0);
    chk("rst_prdata",  32'(prdata[0]),  32'd0);
    chk("rst_wr_en",   32'(wr_en[0]),   32'd0);
    chk("rst_wr_data", 32'(wr_data[0]), 32'd0);
    rst_n = 1'b1;

    // Basic write/read with one wait state.
    xfer(0, 1'b1, 3'd3, 8'hA5);
    chk("w3_lat", 32'(x_lat), 32'd2);
    chk("w3_err", 32'(x_err), 32'd0);
    chk("w3_we",  32'(x_we),  32'(5'b01000));
    chk("w3_wd",  32'(x_wd),  32'hA5);
    xfer(0, 1'b0, 3'd3, 8'h00);
    chk("r3_lat",  32'(x_lat), 32'd2);
    chk("r3_data", 32'(x_rd),  32'hA5);
    chk("r3_err",  32'(x_err), 32'd0);
    chk("r3_we",   32'(x_we),  32'd0);

    // Read-only and out-of-range errors.
    xfer(0, 1'b1, 3'd0, 8'h55);
    chk("w0ro_err", 32'(x_err), 32'd1);
    chk("w0ro_we",  32'(x_we),  32'd0);
    xfer(0, 1'b0, 3'd0, 8'h00);
    chk("r0_err",  32'(x_err), 32'd0);
    chk("r0_data", 32'(x_rd),  32'h00);
    xfer(0, 1'b1, 3'd6, 8'h66);
    chk("w6_err", 32'(x_err), 32'd1);
    chk("w6_we",  32'(x_we),  32'd0);
    xfer(0, 1'b0, 3'd6, 8'h00);
    chk("r6_err",  32'(x_err), 32'd1);
    chk("r6_data", 32'(x_rd),  32'd0);
    xfer(0, 1'b0, 3'd5, 8'h00);
    chk("r5_err",  32'(x_err), 32'd1);

    // Back-to-back write then read of reg 1.
    xfer(0, 1'b1, 3'd1, 8'h3C);
    a1 = x_at;
    chk("b2b_w_we", 32'(x_we), 32'(5'b00010));
    xfer(0, 1'b0, 3'd1, 8'h00);
    chk("b2b_r_data", 32'(x_rd), 32'h3C);
    chk("b2b_gap",    32'(x_at - a1), 32'd3);

    // PENABLE high without a setup phase must be ignored.
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 3'd4; pwdata[0] = 8'hEE;
    hits = 0;
    repeat (4) begin
      @(negedge clk);
      if (pready[0]) hits++;
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    chk("noset_pready", 32'(hits), 32'd0);
    chk("noset_bank4",  32'(bank[0][39:32]), 32'h00);

    // Reset in the middle of a write to reg 2.
    xfer(0, 1'b1, 3'd2, 8'h11);
    chk("w2_we", 32'(x_we), 32'(5'b00100));
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 3'd2; pwdata[0] = 8'h77;
    @(negedge clk);
    penable[0] = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_pready",  32'(pready[0]),  32'd0);
    chk("mrst_wr_en",   32'(wr_en[0]),   32'd0);
    chk("mrst_wr_data", 32'(wr_data[0]), 32'd0);
    chk("mrst_prdata",  32'(prdata[0]),  32'd0);
    @(negedge clk);
    psel[0] = 1'b0; penable[0] = 1'b0;
    rst_n = 1'b1;
    hits = 0;
    repeat (4) begin
      @(negedge clk);
      if (pready[0]) hits++;
    end
    chk("mrst_no_pready", 32'(hits), 32'd0);
    chk("mrst_bank2",     32'(bank[0][23:16]), 32'h11);
    xfer(0, 1'b0, 3'd2, 8'h00);
    chk("mrst_r2", 32'(x_rd), 32'h11);

    // Zero wait states.
    xfer(1, 1'b1, 3'd4, 8'h5A);
    chk("ws0_w_lat", 32'(x_lat), 32'd1);
    chk("ws0_w_we",  32'(x_we),  32'(5'b10000));
    xfer(1, 1'b0, 3'd4, 8'h00);
    chk("ws0_r_lat",  32'(x_lat), 32'd1);
    chk("ws0_r_data", 32'(x_rd),  32'h5A);

    // Three wait states.
    xfer(2, 1'b1, 3'd2, 8'hC3);
    chk("ws3_w_lat", 32'(x_lat), 32'd4);
    chk("ws3_w_we",  32'(x_we),  32'(5'b00100));
    xfer(2, 1'b0, 3'd2, 8'h00);
    chk("ws3_r_lat",  32'(x_lat), 32'd4);
    chk("ws3_r_data", 32'(x_rd),  32'hC3);

    // PSEL dropped during the wait phase aborts the transfer.
    @(negedge clk);
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 3'd3; pwdata[2] = 8'hEE;
    @(negedge clk);
    penable[2] = 1'b1;
    @(negedge clk);
    psel[2] = 1'b0; penable[2] = 1'b0;
    hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (pready[2]) hits++;
    end
    chk("abort_pready", 32'(hits), 32'd0);
    chk("abort_bank3",  32'(bank[2][31:24]), 32'h00);
    xfer(2, 1'b1, 3'd1, 8'h99);
    chk("post_abort_lat", 32'(x_lat), 32'd4);
    chk("post_abort_we",  32'(x_we),  32'(5'b00010));
    xfer(2, 1'b0, 3'd1, 8'h00);
    chk("post_abort_rd",  32'(x_rd),  32'h99);

    @(negedge clk);
    chk("stray_wr_en", 32'(stray), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
